pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
// Parametrised hazard/forwarding controller for the 5-stage IF/ID/EXE/MEM/WB pipeline.
// Tracks destination regs of in-flight instructions (EX, MEM, WB) and decides stalls,
// squashes and forwarding selects. Replaces hard-wired no-hazard sequencing; adds a
// no-forwarding mode and saturating stall/flush performance counters.
// PARAMETERS
// REG_AW   5   register-address width (2**REG_AW architectural regs, reg 0 hard-wired zero)
// FWD_EN   1   1: forward from EX/MEM and MEM/WB; 0: stall until writer reaches WB
// CNT_W    16  width of stall_cnt / flush_cnt
// PORTS
// clk           in   1       clock, rising edge
// rst           in   1       reset, asynchronous, active-high
// id_valid      in   1       ID holds a real instruction
// id_rs, id_rt  in   REG_AW  source regs of ID instruction
// id_use_rs/rt  in   1       ID instruction actually reads rs / rt
// id_rd         in   REG_AW  destination reg of ID instruction
// id_reg_write  in   1       ID instruction writes id_rd
// id_is_load    in   1       ID instruction is a load (data valid only after MEM)
// id_jump       in   1       ID instruction is a jump (target known in ID)
// ex_br_taken   in   1       branch in EX resolved taken this cycle
// stall_if      out  1       hold PC and IF/ID register
// bubble_ex     out  1       load NOP into ID/EX register
// flush_if      out  1       squash instruction in IF/ID register
// fwd_rs_sel    out  2       operand-A select for EX instruction (registered)
// fwd_rt_sel    out  2       operand-B select for EX instruction (registered)
// stall_cnt     out  CNT_W   cycles with stall_if=1, saturating
// flush_cnt     out  CNT_W   cycles with flush_if=1, saturating
// BEHAVIOUR
// - Tracking slots EX, MEM, WB each hold {valid, rd, reg_write, is_load}; every cycle
//   EX->MEM->WB shift unconditionally; ID->EX loads ID entry, or invalid if bubble_ex.
// - "match(s,r)": slot s valid & reg_write & rd==r & r!=0 & ID operand used & id_valid.
// - FWD_EN=1: stall = match(EX,rs|rt) & EX.is_load (load-use, exactly 1 cycle).
// - FWD_EN=0: stall = match(EX) | match(MEM); WB match not a hazard (RF write-before-read).
// - ex_br_taken: flush_if=1, bubble_ex=1, stall_if=0 (branch overrides stall same cycle).
// - else stall: stall_if=1, bubble_ex=1, flush_if=0.
// - else id_jump & id_valid: flush_if=1, bubble_ex=0 (jump advances, IF squashed).
// - stall_if/bubble_ex/flush_if combinational from slots and inputs, same cycle.
// - fwd_*_sel registered at ID->EX advance: 2'd1 if match(EX) (will be in MEM),
//   else 2'd2 if match(MEM) (will be in WB), else 2'd0; EX priority over MEM.
//   On bubble (stall/flush) sels load 2'd0. FWD_EN=0: sels constant 2'd0. 2'd3 never driven.
// - Counters increment by 1 per qualifying cycle, hold at 2**CNT_W-1 (no wrap).
// - Reset (async, any cycle incl. mid-stall): all slots invalid, fwd sels 0, counters 0;
//   hence stall_if=bubble_ex=0, flush_if follows inputs only.
// STRUCTURE
// - Shared package: FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2; stage-slot struct
//   typedef {valid, rd, reg_write, is_load}.
// - One sub-module: hazard_sat_counter (CNT_W, inc, clk, rst), instanced twice.
// TESTING
// - add r8 in EX, ID sub reads r8, FWD_EN=1 -> no stall; next cycle fwd_rs_sel=1.
// - lw r9 in EX, ID add reads r9 -> stall_if=1,bubble_ex=1 one cycle; then fwd_rt_sel=2.
// - ex_br_taken=1 together with load-use hazard -> flush_if=1,bubble_ex=1,stall_if=0.
// - FWD_EN=0, writer of r10 in EX, reader in ID -> stall 2 cycles, sels stay 0.
// - Writer of r0 in EX, ID reads r0 -> no stall, sel 0; id_jump=1 -> flush_if=1 one cycle.
// - CNT_W=2, 5 stall cycles -> stall_cnt=3; assert rst mid-stall -> all outputs 0 at once.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select codes, the
// per-stage tracking slot and the register-match helper.
package pipe_hazard_unit_pkg;

  // Slot rd field is sized for the widest supported register file; narrower
  // REG_AW values are zero-extended into it.
  localparam int MAX_REG_AW = 8;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;
  localparam int N_SLOTS  = 3;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } slot_t;

  // True when an in-flight writer produces the register an ID operand reads.
  function automatic logic slot_match(input slot_t s,
                                      input logic [MAX_REG_AW-1:0] r,
                                      input logic used,
                                      input logic id_valid);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0) && used && id_valid;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Saturating event counter: counts cycles with inc high, holds at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for a 5-stage pipeline: tracks EX/MEM/WB writers,
// drives stall/bubble/flush combinationally and registers EX forwarding selects.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_jump,
  input  logic              ex_br_taken,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  slot_t r_slot [N_SLOTS];
  logic [1:0] r_fwd_rs_sel;
  logic [1:0] r_fwd_rt_sel;

  logic [MAX_REG_AW-1:0] w_rs;
  logic [MAX_REG_AW-1:0] w_rt;
  slot_t w_id_slot;
  logic  w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic  w_hazard;
  logic  w_stall, w_bubble, w_flush;

  assign w_rs = MAX_REG_AW'(id_rs);
  assign w_rt = MAX_REG_AW'(id_rt);

  always_comb begin
    w_id_slot           = '0;
    w_id_slot.valid     = id_valid;
    w_id_slot.rd        = MAX_REG_AW'(id_rd);
    w_id_slot.reg_write = id_reg_write;
    w_id_slot.is_load   = id_is_load;
  end

  assign w_ex_rs  = slot_match(r_slot[SLOT_EX],  w_rs, id_use_rs, id_valid);
  assign w_ex_rt  = slot_match(r_slot[SLOT_EX],  w_rt, id_use_rt, id_valid);
  assign w_mem_rs = slot_match(r_slot[SLOT_MEM], w_rs, id_use_rs, id_valid);
  assign w_mem_rt = slot_match(r_slot[SLOT_MEM], w_rt, id_use_rt, id_valid);

  // Without forwarding a reader must wait until the writer sits in WB, where
  // the register file's write-before-read makes the value visible.
  always_comb begin
    w_hazard = 1'b0;
    if (FWD_EN != 0) begin
      w_hazard = (w_ex_rs || w_ex_rt) && r_slot[SLOT_EX].is_load;
    end else begin
      w_hazard = w_ex_rs || w_ex_rt || w_mem_rs || w_mem_rt;
    end
  end

  // A taken branch wins over a stall: the stalled ID instruction is on the
  // wrong path anyway, so it is squashed rather than held.
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (ex_br_taken) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_hazard) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end else if (id_jump && id_valid) begin
      w_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_slot[SLOT_WB]  <= r_slot[SLOT_MEM];
      r_slot[SLOT_MEM] <= r_slot[SLOT_EX];
      r_slot[SLOT_EX]  <= w_bubble ? '0 : w_id_slot;
    end
  end

  // Selects describe where the operand lives once ID has moved into EX: the
  // current EX writer will then be in MEM, the current MEM writer in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_rs_sel <= FWD_RF;
      r_fwd_rt_sel <= FWD_RF;
    end else if ((FWD_EN == 0) || w_bubble) begin
      r_fwd_rs_sel <= FWD_RF;
      r_fwd_rt_sel <= FWD_RF;
    end else begin
      r_fwd_rs_sel <= w_ex_rs ? FWD_EXMEM : (w_mem_rs ? FWD_MEMWB : FWD_RF);
      r_fwd_rt_sel <= w_ex_rt ? FWD_EXMEM : (w_mem_rt ? FWD_MEMWB : FWD_RF);
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall),
    .o_cnt (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush),
    .o_cnt (flush_cnt)
  );

  assign stall_if   = w_stall;
  assign bubble_ex  = w_bubble;
  assign flush_if   = w_flush;
  assign fwd_rs_sel = r_fwd_rs_sel;
  assign fwd_rt_sel = r_fwd_rt_sel;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench: three hazard units (forwarding, no-forwarding, 2-bit counters)
// share one ID/EX stimulus stream; each step checks hand-computed outputs.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load, id_jump;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_br_taken;

  logic        a_stall, a_bubble, a_flush;
  logic [1:0]  a_rs_sel, a_rt_sel;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        n_stall, n_bubble, n_flush;
  logic [1:0]  n_rs_sel, n_rt_sel;
  logic [15:0] n_stall_cnt, n_flush_cnt;
  logic        c_stall, c_bubble, c_flush;
  logic [1:0]  c_rs_sel, c_rt_sel;
  logic [1:0]  c_stall_cnt, c_flush_cnt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_jump(id_jump),
    .ex_br_taken(ex_br_taken), .stall_if(a_stall), .bubble_ex(a_bubble),
    .flush_if(a_flush), .fwd_rs_sel(a_rs_sel), .fwd_rt_sel(a_rt_sel),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_jump(id_jump),
    .ex_br_taken(ex_br_taken), .stall_if(n_stall), .bubble_ex(n_bubble),
    .flush_if(n_flush), .fwd_rs_sel(n_rs_sel), .fwd_rt_sel(n_rt_sel),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt));

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_jump(id_jump),
    .ex_br_taken(ex_br_taken), .stall_if(c_stall), .bubble_ex(c_bubble),
    .flush_if(c_flush), .fwd_rs_sel(c_rs_sel), .fwd_rt_sel(c_rt_sel),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic jmp);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    id_jump      = jmp;
    #1;
  endtask

  task automatic nop;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain;
    for (int i = 0; i < 3; i++) begin
      nop();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_br_taken = 1'b0;
    nop();
    #11;
    chk("rst_stall", a_stall, 0);
    chk("rst_bubble", a_bubble, 0);
    chk("rst_flush", a_flush, 0);
    chk("rst_rs_sel", a_rs_sel, 0);
    chk("rst_stall_cnt", a_stall_cnt, 0);
    rst = 1'b0;
    tick();

    // add r8 in EX, sub reads r8: forwarded, no stall
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("alu_fwd_no_stall", a_stall, 0);
    chk("alu_fwd_no_bubble", a_bubble, 0);
    chk("nofwd_alu_stall", n_stall, 1);
    tick();
    chk("alu_fwd_rs_sel", a_rs_sel, 1);
    chk("alu_fwd_rt_sel", a_rt_sel, 0);
    drain();

    // lw r9 in EX, add reads r9 on rt: one-cycle load-use stall, then MEM/WB fwd
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", a_stall, 1);
    chk("lu_bubble", a_bubble, 1);
    chk("lu_flush", a_flush, 0);
    tick();
    chk("lu_stall_released", a_stall, 0);
    chk("lu_bubble_sel", a_rt_sel, 0);
    tick();
    chk("lu_rt_sel_memwb", a_rt_sel, 2);
    chk("lu_rs_sel_rf", a_rs_sel, 0);
    chk("lu_stall_cnt", a_stall_cnt, 1);
    drain();

    // taken branch in the same cycle as a load-use hazard
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    ex_br_taken = 1'b1;
    #1;
    chk("br_flush", a_flush, 1);
    chk("br_bubble", a_bubble, 1);
    chk("br_no_stall", a_stall, 0);
    tick();
    ex_br_taken = 1'b0;
    nop();
    chk("br_rt_sel_zero", a_rt_sel, 0);
    chk("br_flush_cnt", a_flush_cnt, 1);
    chk("br_stall_cnt_held", a_stall_cnt, 1);
    drain();

    // no-forwarding: writer of r10 in EX, reader waits two cycles
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    chk("nf_stall_ex", n_stall, 1);
    chk("nf_bubble_ex", n_bubble, 1);
    chk("fwd_unit_no_stall", a_stall, 0);
    tick();
    chk("nf_stall_mem", n_stall, 1);
    chk("nf_rs_sel_1", n_rs_sel, 0);
    chk("fwd_unit_rs_sel", a_rs_sel, 1);
    tick();
    chk("nf_stall_wb_clear", n_stall, 0);
    chk("nf_rs_sel_2", n_rs_sel, 0);
    tick();
    chk("nf_rs_sel_3", n_rs_sel, 0);
    drain();

    // four more load-use stalls: 5 total saturates a 2-bit counter at 3
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      nop();
      tick();
      tick();
    end
    chk("sat_stall_cnt_wide", a_stall_cnt, 5);
    chk("sat_stall_cnt_c2", c_stall_cnt, 3);

    // reset asserted in the middle of a stall
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_stall", c_stall, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", a_stall, 0);
    chk("mid_rst_bubble", a_bubble, 0);
    chk("mid_rst_flush", a_flush, 0);
    chk("mid_rst_stall_cnt", a_stall_cnt, 0);
    chk("mid_rst_flush_cnt", a_flush_cnt, 0);
    chk("mid_rst_c2_cnt", c_stall_cnt, 0);
    chk("mid_rst_c2_stall", c_stall, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", a_stall, 0);
    tick();
    drain();

    // load to r0 never creates a hazard; jump squashes IF for one cycle
    issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("r0_no_stall", a_stall, 0);
    chk("r0_nf_no_stall", n_stall, 0);
    tick();
    chk("r0_rs_sel", a_rs_sel, 0);
    chk("r0_rt_sel", a_rt_sel, 0);
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("jump_flush", a_flush, 1);
    chk("jump_no_bubble", a_bubble, 0);
    chk("jump_no_stall", a_stall, 0);
    tick();
    nop();
    chk("jump_flush_drop", a_flush, 0);
    chk("jump_flush_cnt", a_flush_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
